// File: rtl/snif_poke_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snif_poke_pkg : shared defaults, FSM encoding and doorbell-address helper   |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
package snif_poke_pkg;

    localparam int c_adr_width       = 6;
    localparam int c_dat_width       = 8;
    localparam int c_fifo_depth_log2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DBELL = 2'd3
    } state_t;

    // The doorbell is the top of the address space.
    function automatic logic [31:0] dbell_adr(input int adr_width);
        return (32'd1 << adr_width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snif_poke_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with occupancy count, full/empty flags        |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH      = 14,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full_o  = (r_count == (DEPTH_LOG2+1)'(c_depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign rdata_o = r_mem[r_rd_ptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/snif_poke.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snif_poke : queued bus write initiator (request/grant, single-cycle writes) |
// |             Optional doorbell write after each command: SNIF_POKE_DOORBELL_EN|
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module snif_poke
    import snif_poke_pkg::*;
#(
    parameter int ADR_WIDTH       = c_adr_width,
    parameter int DAT_WIDTH       = c_dat_width,
    parameter int FIFO_DEPTH_LOG2 = c_fifo_depth_log2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [ADR_WIDTH-1:0]       cmd_adr_i,
    input  logic [DAT_WIDTH-1:0]       cmd_dat_i,
    output logic                       bus_req_o,
    input  logic                       bus_gnt_i,
    output logic [ADR_WIDTH-1:0]       adr_o,
    output logic [DAT_WIDTH-1:0]       dat_o,
    output logic                       we_o,
    output logic                       busy_o,
    output logic [FIFO_DEPTH_LOG2:0]   count_o
);

    localparam int c_entry_w = ADR_WIDTH + DAT_WIDTH;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_bus_req;
    logic                     r_we;
    logic [ADR_WIDTH-1:0]     r_adr;
    logic [DAT_WIDTH-1:0]     r_dat;
    logic                     w_bus_req_nxt;
    logic                     w_we_nxt;
    logic [ADR_WIDTH-1:0]     w_adr_nxt;
    logic [DAT_WIDTH-1:0]     w_dat_nxt;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [c_entry_w-1:0]     w_head;
    logic [FIFO_DEPTH_LOG2:0] w_count;

`ifdef SNIF_POKE_DOORBELL_EN
    localparam logic [ADR_WIDTH-1:0] c_dbell_adr = ADR_WIDTH'(dbell_adr(ADR_WIDTH));
`endif

    sync_fifo #(
        .WIDTH      (c_entry_w),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .pop_i   (w_pop),
        .wdata_i ({cmd_adr_i, cmd_dat_i}),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_bus_req <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_req <= w_bus_req_nxt;
            r_we      <= w_we_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
        end
    end

    // A launched write always completes; grant only gates the next launch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_we_nxt    = 1'b0;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt_i && !w_empty) begin
                    w_pop       = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_adr_nxt   = w_head[c_entry_w-1:DAT_WIDTH];
                    w_dat_nxt   = w_head[DAT_WIDTH-1:0];
                    w_state_nxt = ST_WRITE;
                end
            end
`ifdef SNIF_POKE_DOORBELL_EN
            ST_WRITE: begin
                w_we_nxt    = 1'b1;
                w_adr_nxt   = c_dbell_adr;
                w_dat_nxt   = '0;
                w_state_nxt = ST_DBELL;
            end
            ST_DBELL: begin
`else
            ST_WRITE: begin
`endif
                if (bus_gnt_i && !w_empty) begin
                    w_pop       = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_adr_nxt   = w_head[c_entry_w-1:DAT_WIDTH];
                    w_dat_nxt   = w_head[DAT_WIDTH-1:0];
                    w_state_nxt = ST_WRITE;
                end else if (!w_empty) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_bus_req_nxt = (w_state_nxt != ST_IDLE);
    end

    assign cmd_ready_o = ~w_full;
    assign bus_req_o   = r_bus_req;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign count_o     = w_count;
    assign busy_o      = (w_count != '0) | r_we | (r_state != ST_IDLE);

endmodule
`default_nettype wire
